// File: rtl/shifter_pkg.sv
// Shared constants for the shift/rotate engine: mode codes and FSM state encoding.
package shifter_pkg;

  localparam logic [2:0] MODE_LSL = 3'b000;
  localparam logic [2:0] MODE_LSR = 3'b001;
  localparam logic [2:0] MODE_ASR = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Combinational step of the shifter: moves val by k (0..STEP) positions in the given mode.
// carry is the last bit that left val during this step, 0 when k is 0.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] val,
  input  logic [KW-1:0]    k,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] shifted,
  output logic             carry
);

  // Unrolled chain of single-bit moves; positions beyond k pass the value through.
  always_comb begin
    shifted = val;
    carry   = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(k)) begin
        case (mode)
          MODE_LSL: begin
            carry   = shifted[WIDTH-1];
            shifted = {shifted[WIDTH-2:0], 1'b0};
          end
          MODE_LSR: begin
            carry   = shifted[0];
            shifted = {1'b0, shifted[WIDTH-1:1]};
          end
          MODE_ASR: begin
            carry   = shifted[0];
            shifted = {shifted[WIDTH-1], shifted[WIDTH-1:1]};
          end
          MODE_ROL: begin
            carry   = shifted[WIDTH-1];
            shifted = {shifted[WIDTH-2:0], shifted[WIDTH-1]};
          end
          MODE_ROR: begin
            carry   = shifted[0];
            shifted = {shifted[0], shifted[WIDTH-1:1]};
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate engine with start/busy/done handshake and carry-out.
// Handshake: start is taken only in IDLE; busy is high while shifting; done pulses one cycle with result/carry valid.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   value_in,
  input  logic [SHAMT_W-1:0] amount,
  input  logic [2:0]         mode,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               carry,
  output logic [1:0]         fsm_state
);

  localparam int KW = $clog2(STEP + 1);

  state_t             state;
  state_t             state_nx;
  logic [WIDTH-1:0]   val_r;
  logic [WIDTH-1:0]   val_nx;
  logic [SHAMT_W-1:0] cnt_r;
  logic [2:0]         mode_r;
  logic               carry_r;
  logic               step_carry;
  logic [KW-1:0]      k_step;

  always_comb begin
    k_step = (cnt_r > SHAMT_W'(STEP)) ? KW'(STEP) : KW'(cnt_r);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .val     (val_r),
    .k       (k_step),
    .mode    (mode_r),
    .shifted (val_nx),
    .carry   (step_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_SHIFT;
      S_SHIFT: if (cnt_r == '0) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_SHIFT);
    done      = (state == S_DONE);
    fsm_state = state;
  end

  // Pass-through modes start with a zero count so they finish like amount==0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_r   <= '0;
      cnt_r   <= '0;
      mode_r  <= MODE_LSL;
      carry_r <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            val_r   <= value_in;
            mode_r  <= mode;
            carry_r <= 1'b0;
            cnt_r   <= (mode > MODE_ROR) ? '0 : amount;
          end
        end
        S_SHIFT: begin
          if (cnt_r != '0) begin
            val_r   <= val_nx;
            carry_r <= step_carry;
            cnt_r   <= cnt_r - SHAMT_W'(k_step);
          end else begin
            result <= val_r;
            carry  <= carry_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: STEP=1 and STEP=4 instances share stimulus and are checked against a reference model.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] value_in = '0;
  logic [4:0]  amount = '0;
  logic [2:0]  mode = '0;

  logic        busy1, done1, carry1;
  logic [15:0] result1;
  logic [1:0]  state1;
  logic        busy4, done4, carry4;
  logic [15:0] result4;
  logic [1:0]  state4;

  int n_checks = 0;
  int n_fail   = 0;
  int steps[2] = '{1, 4};

  logic [15:0] exp_q[$];

  logic [15:0] obs_res[2];
  logic [15:0] obs_hold[2];
  logic        obs_car[2];
  int          obs_lat[2];
  int          obs_done[2];
  int          obs_busy[2];

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(16), .SHAMT_W(5), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .value_in(value_in), .amount(amount), .mode(mode),
    .busy(busy1), .done(done1), .result(result1), .carry(carry1), .fsm_state(state1)
  );

  seq_shifter #(.WIDTH(16), .SHAMT_W(5), .STEP(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .value_in(value_in), .amount(amount), .mode(mode),
    .busy(busy4), .done(done4), .result(result4), .carry(carry4), .fsm_state(state4)
  );

  // Reference model: whole-operation result from wide arithmetic, not bit-by-bit stepping.
  function automatic void model(input logic [15:0] v, input logic [4:0] a, input logic [2:0] m,
                                output logic [15:0] r, output logic c);
    logic [63:0] x;
    logic [31:0] vv;
    int s;
    vv = {16'h0, v};
    s  = int'(a) % 16;
    r  = v;
    c  = 1'b0;
    case (m)
      3'd0: begin x = {48'h0, v} << a; r = x[15:0]; c = x[16]; end
      3'd1: begin x = {16'h0, v, 32'h0} >> a; r = x[47:32]; c = x[31]; end
      3'd2: begin x = $signed({{16{v[15]}}, v, 32'h0}) >>> a; r = x[47:32]; c = x[31]; end
      3'd3: if (a != 0) begin vv = (vv << s) | (vv >> (16 - s)); r = vv[15:0]; c = r[0]; end
      3'd4: if (a != 0) begin vv = (vv >> s) | (vv << (16 - s)); r = vv[15:0]; c = r[15]; end
      default: ;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] a, input logic [2:0] m, input int st);
    if (m > 3'd4 || a == 0) return 1;
    return 1 + (int'(a) + st - 1) / st;
  endfunction

  // Drives one operation and records what both instances did over a fixed window.
  // hold > 0 keeps start asserted with random operands for that many cycles after the accept.
  task automatic run_op(input logic [15:0] v, input logic [4:0] a, input logic [2:0] m, input int hold);
    logic dn, bz, cr;
    logic [15:0] rs;
    for (int d = 0; d < 2; d++) begin
      obs_lat[d] = -1; obs_done[d] = 0; obs_busy[d] = 0; obs_res[d] = '0; obs_car[d] = 1'b0;
    end
    @(negedge clk);
    value_in = v; amount = a; mode = m; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      for (int d = 0; d < 2; d++) begin
        dn = (d == 0) ? done1 : done4;
        bz = (d == 0) ? busy1 : busy4;
        rs = (d == 0) ? result1 : result4;
        cr = (d == 0) ? carry1 : carry4;
        if (bz) obs_busy[d]++;
        if (dn) begin
          obs_done[d]++;
          if (obs_lat[d] < 0) begin obs_lat[d] = n; obs_res[d] = rs; obs_car[d] = cr; end
        end
      end
      if (n < hold) begin
        start = 1'b1; value_in = 16'($urandom); amount = 5'($urandom); mode = 3'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    obs_hold[0] = result1;
    obs_hold[1] = result4;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy1, done1, carry1, result1, state1} !== 20'h0) begin
      n_fail++; $display("FAIL reset_step1 got=%h want=0", {busy1, done1, carry1, result1, state1});
    end
    n_checks++;
    if ({busy4, done4, carry4, result4, state4} !== 20'h0) begin
      n_fail++; $display("FAIL reset_step4 got=%h want=0", {busy4, done4, carry4, result4, state4});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed;
    logic [15:0] dv[6] = '{16'h0001, 16'h8000, 16'h0001, 16'h8001, 16'hABCD, 16'hABCD};
    logic [4:0]  da[6] = '{5'd4, 5'd15, 5'd1, 5'd16, 5'd0, 5'd9};
    logic [2:0]  dm[6] = '{3'd0, 3'd2, 3'd4, 3'd3, 3'd1, 3'd7};
    logic [15:0] er;
    logic        ec;
    int          el;
    for (int i = 0; i < 6; i++) begin
      run_op(dv[i], da[i], dm[i], 0);
      model(dv[i], da[i], dm[i], er, ec);
      for (int d = 0; d < 2; d++) begin
        el = exp_lat(da[i], dm[i], steps[d]);
        n_checks++;
        if (obs_res[d] !== er) begin
          n_fail++; $display("FAIL directed_result op=%0d step=%0d got=%h want=%h", i, steps[d], obs_res[d], er);
        end
        n_checks++;
        if (obs_car[d] !== ec) begin
          n_fail++; $display("FAIL directed_carry op=%0d step=%0d got=%b want=%b", i, steps[d], obs_car[d], ec);
        end
        n_checks++;
        if (obs_lat[d] != el || obs_done[d] != 1) begin
          n_fail++; $display("FAIL directed_done op=%0d step=%0d lat=%0d pulses=%0d want lat=%0d pulses=1",
                             i, steps[d], obs_lat[d], obs_done[d], el);
        end
        n_checks++;
        if (obs_busy[d] != el) begin
          n_fail++; $display("FAIL directed_busy op=%0d step=%0d got=%0d want=%0d", i, steps[d], obs_busy[d], el);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] v, er, eq;
    logic [4:0]  a;
    logic [2:0]  m;
    logic        ec;
    int          el;
    for (int i = 0; i < 40; i++) begin
      v = 16'($urandom);
      a = 5'($urandom_range(0, 31));
      m = 3'($urandom_range(0, 7));
      model(v, a, m, er, ec);
      exp_q.push_back(er);
      run_op(v, a, m, 0);
      eq = exp_q.pop_front();
      for (int d = 0; d < 2; d++) begin
        el = exp_lat(a, m, steps[d]);
        n_checks++;
        if (obs_res[d] !== eq || obs_hold[d] !== eq) begin
          n_fail++; $display("FAIL random_result v=%h a=%0d m=%0d step=%0d got=%h held=%h want=%h",
                             v, a, m, steps[d], obs_res[d], obs_hold[d], eq);
        end
        n_checks++;
        if (obs_car[d] !== ec) begin
          n_fail++; $display("FAIL random_carry v=%h a=%0d m=%0d step=%0d got=%b want=%b", v, a, m, steps[d], obs_car[d], ec);
        end
        n_checks++;
        if (obs_lat[d] != el || obs_done[d] != 1) begin
          n_fail++; $display("FAIL random_done v=%h a=%0d m=%0d step=%0d lat=%0d pulses=%0d want lat=%0d pulses=1",
                             v, a, m, steps[d], obs_lat[d], obs_done[d], el);
        end
      end
    end
  endtask

  task automatic test_busy_ignore;
    logic [15:0] er;
    logic        ec;
    int          el;
    model(16'h1357, 5'd8, 3'd3, er, ec);
    // Start stays high through the STEP=4 instance's DONE cycle as well as its SHIFT cycles.
    run_op(16'h1357, 5'd8, 3'd3, exp_lat(5'd8, 3'd3, 4) + 1);
    for (int d = 0; d < 2; d++) begin
      el = exp_lat(5'd8, 3'd3, steps[d]);
      n_checks++;
      if (obs_res[d] !== er || obs_car[d] !== ec) begin
        n_fail++; $display("FAIL busy_ignore_result step=%0d got=%h/%b want=%h/%b", steps[d], obs_res[d], obs_car[d], er, ec);
      end
      n_checks++;
      if (obs_lat[d] != el || obs_done[d] != 1) begin
        n_fail++; $display("FAIL busy_ignore_done step=%0d lat=%0d pulses=%0d want lat=%0d pulses=1",
                           steps[d], obs_lat[d], obs_done[d], el);
      end
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    @(negedge clk);
    value_in = 16'h1234; amount = 5'd20; mode = 3'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({busy1, done1, carry1, result1} !== 19'h0) begin
      n_fail++; $display("FAIL reset_mid_step1 got=%h want=0", {busy1, done1, carry1, result1});
    end
    n_checks++;
    if ({busy4, done4, carry4, result4} !== 19'h0) begin
      n_fail++; $display("FAIL reset_mid_step4 got=%h want=0", {busy4, done4, carry4, result4});
    end
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (done1 || done4 || busy1 || busy4) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL reset_mid_no_done got=%0d want=0 active cycles", pulses);
    end
    run_op(16'h00F0, 5'd4, 3'd1, 0);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_res[d] !== 16'h000F || obs_car[d] !== 1'b0 || obs_done[d] != 1) begin
        n_fail++; $display("FAIL reset_mid_recover step=%0d got=%h/%b pulses=%0d want=000f/0 pulses=1",
                           steps[d], obs_res[d], obs_car[d], obs_done[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
